regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Write-back buffer between the two execution units and the dual-port register file.
//  Queues each unit's result writes in a per-channel FIFO and issues them on the
//  file's write ports in strict age order. Never presents both ports with the same
//  destination in one cycle, which would block both ports.
//  Exposes a pending-write mask so operand fetch can stall on queued results.
// PARAMETERS
//  DEPTH    4   entries per channel FIFO (power of 2, >=2)
//  STAMP_W  4   age-stamp width; must be >= log2(2*DEPTH)+1
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   asynchronous, active-low reset (0 = reset)
//  in1_vld  in   1   channel 1 write request valid
//  in1_rdy  out  1   channel 1 can accept (FIFO not full)
//  in1_reg  in   3   channel 1 destination register
//  in1_dat  in   16  channel 1 write data
//  in2_vld/in2_rdy/in2_reg/in2_dat   same as channel 1, for channel 2
//  cs1      out  3   register file port 1 write select
//  cw1      out  1   register file port 1 write enable
//  cd1      out  16  register file port 1 write data
//  WT1      in   1   register file port 1 wait (write not taken)
//  cs2/cw2/cd2/WT2   same as port 1, for port 2 (fed by channel 2)
//  pend     out  8   bit r = 1 while any queued entry targets register r
// BEHAVIOUR
//  - Reset (rst=0, async): both FIFOs empty, stamp counter = 0.
//    Outputs while in reset: cw1=cw2=0, pend=0, in1_rdy=in2_rdy=1, cs*/cd* = 0.
//  - Enqueue: at a rising edge with inN_vld && inN_rdy, push {reg, dat, stamp}.
//    inN_rdy = !fullN and is derived only from registered state.
//    No bypass: a push while full is impossible (rdy=0). vld while rdy=0 is ignored.
//  - Stamp counter: increments by 1 (mod 2^STAMP_W) on any edge with >=1 push.
//    Same-edge pushes on both channels share one stamp.
//  - Issue (combinational from FIFO heads):
//    - Channel N head valid -> cwN=1, csN=head reg, cdN=head dat.
//    - Latency: a pushed entry is visible on cw/cs/cd in the cycle after its push edge.
//    - Collision (both heads valid, same reg): only the older head is issued;
//      the other channel's cw is 0.
//    - Older = smaller stamp by modular compare ((s1-s2) mod 2^STAMP_W with MSB set
//      => s1 older). On a stamp tie, channel 1 is older, so channel 2's value lands last.
//  - Pop: at an edge with cwN && !WTN, channel N's head is removed.
//    If WTN=1, the head is held and re-presented unchanged.
//  - Empty/full: push and pop on the same edge are both allowed when not full
//    (count unchanged). Pointers wrap mod DEPTH.
//  - pend: OR over all valid entries of both FIFOs, decoded by reg, combinational.
//    A bit clears in the cycle after the last matching pop.
//  - Reset mid-operation: all queued entries are discarded (no write issued);
//    cw drops immediately (async).
// TESTING
//  1. in1 {r3, 0x1234} pushed, WT=0 -> next cycle cw1=1 cs1=3 cd1=0x1234.
//     pend[3]=1 for one cycle, then 0.
//  2. Same edge: in1 {r5,0xAAAA}, in2 {r5,0xBBBB}.
//     -> cycle 1: cw1=1, cw2=0. Cycle 2: cw2=1 cd2=0xBBBB. r5 ends 0xBBBB.
//  3. in2 {r2,0x0002} at edge 0, in1 {r2,0x0001} at edge 1, port 2 held by WT2=1 for
//     3 cycles -> cw1 stays 0 until the ch2 entry pops; final r2=0x0001.
//  4. Push 4 entries on ch1 with WT1 forced 1 -> in1_rdy=0 after the 4th.
//     A 5th vld is dropped. Releasing WT1 drains 4 writes in push order.
//  5. Push 20 entries alternating channels with mixed collisions.
//     -> stamp wrap handled; register file contents match an in-order golden model.
//  6. Queue 3 entries, drive rst=0 mid-cycle -> cw1=cw2=0 and pend=0 immediately.
//     After release, no stale write is issued.

Source files
------------

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - two-channel write-back buffer feeding a dual-port register file.
// Each channel queues its results in a FIFO; colliding heads are resolved by age stamp.
module regfile_writeback #(
  parameter int DEPTH   = 4,
  parameter int STAMP_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in1_vld,
  output logic        in1_rdy,
  input  logic [2:0]  in1_reg,
  input  logic [15:0] in1_dat,
  input  logic        in2_vld,
  output logic        in2_rdy,
  input  logic [2:0]  in2_reg,
  input  logic [15:0] in2_dat,
  output logic [2:0]  cs1,
  output logic        cw1,
  output logic [15:0] cd1,
  input  logic        WT1,
  output logic [2:0]  cs2,
  output logic        cw2,
  output logic [15:0] cd2,
  input  logic        WT2,
  output logic [7:0]  pend
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]         r;
    logic [15:0]        d;
    logic [STAMP_W-1:0] s;
  } entry_t;

  entry_t             mem_q  [2][DEPTH];
  entry_t             mem_d  [2][DEPTH];
  logic [DEPTH-1:0]   val_q  [2];
  logic [DEPTH-1:0]   val_d  [2];
  logic [AW-1:0]      wptr_q [2];
  logic [AW-1:0]      wptr_d [2];
  logic [AW-1:0]      rptr_q [2];
  logic [AW-1:0]      rptr_d [2];
  logic [STAMP_W-1:0] stamp_q, stamp_d;

  entry_t             head   [2];
  logic [2:0]         reg_i  [2];
  logic [15:0]        dat_i  [2];
  logic [1:0]         vld_i, wt_i, rdy, head_v, push, pop, cw;
  logic [STAMP_W-1:0] age_diff;
  logic               ch1_older, collide;

  assign vld_i = {in2_vld, in1_vld};
  assign wt_i  = {WT2, WT1};
  assign reg_i[0] = in1_reg;
  assign reg_i[1] = in2_reg;
  assign dat_i[0] = in1_dat;
  assign dat_i[1] = in2_dat;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      head[c]   = mem_q[c][rptr_q[c]];
      head_v[c] = val_q[c][rptr_q[c]];
      rdy[c]    = ~(&val_q[c]);
    end
  end

  // Modular age compare keeps working across stamp wrap; a tie favours channel 1.
  always_comb begin
    age_diff  = head[0].s - head[1].s;
    ch1_older = age_diff[STAMP_W-1] | (age_diff == '0);
    collide   = (&head_v) & (head[0].r == head[1].r);
    cw[0]     = head_v[0] & ~(collide & ~ch1_older);
    cw[1]     = head_v[1] & ~(collide & ch1_older);
  end

  assign push = vld_i & rdy;
  assign pop  = cw & ~wt_i;

  always_comb begin
    mem_d   = mem_q;
    stamp_d = stamp_q;
    for (int c = 0; c < 2; c++) begin
      val_d[c]  = val_q[c];
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      if (push[c]) begin
        mem_d[c][wptr_q[c]] = '{r: reg_i[c], d: dat_i[c], s: stamp_q};
        val_d[c][wptr_q[c]] = 1'b1;
        wptr_d[c]           = wptr_q[c] + AW'(1);
      end
      if (pop[c]) begin
        val_d[c][rptr_q[c]] = 1'b0;
        rptr_d[c]           = rptr_q[c] + AW'(1);
      end
    end
    if (|push) stamp_d = stamp_q + STAMP_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_q <= '0;
      for (int c = 0; c < 2; c++) begin
        val_q[c]  <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      stamp_q <= stamp_d;
      for (int c = 0; c < 2; c++) begin
        val_q[c]  <= val_d[c];
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
    end
  end

  // Payload storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    pend = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++)
        if (val_q[c][i]) pend[mem_q[c][i].r] = 1'b1;
  end

  assign in1_rdy = rdy[0];
  assign in2_rdy = rdy[1];
  assign cw1     = cw[0];
  assign cw2     = cw[1];
  assign cs1     = cw[0] ? head[0].r : 3'd0;
  assign cd1     = cw[0] ? head[0].d : 16'd0;
  assign cs2     = cw[1] ? head[1].r : 3'd0;
  assign cd2     = cw[1] ? head[1].d : 16'd0;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - randomized and directed bench for regfile_writeback.
// Reference model: integer-aged queues per channel plus a register file image.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in1_vld, in1_rdy, in2_vld, in2_rdy;
  logic [2:0]  in1_reg, in2_reg, cs1, cs2;
  logic [15:0] in1_dat, in2_dat, cd1, cd2;
  logic        cw1, cw2, WT1, WT2;
  logic [7:0]  pend;

  regfile_writeback #(.DEPTH(DEPTH), .STAMP_W(4)) dut (
    .clk(clk), .rst(rst),
    .in1_vld(in1_vld), .in1_rdy(in1_rdy), .in1_reg(in1_reg), .in1_dat(in1_dat),
    .in2_vld(in2_vld), .in2_rdy(in2_rdy), .in2_reg(in2_reg), .in2_dat(in2_dat),
    .cs1(cs1), .cw1(cw1), .cd1(cd1), .WT1(WT1),
    .cs2(cs2), .cw2(cw2), .cd2(cd2), .WT2(WT2),
    .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] d;
    int          age;
  } ent_t;

  ent_t        q1[$];
  ent_t        q2[$];
  int          edge_no = 0;
  logic [15:0] rf_model[8];
  logic [15:0] rf_dut[8];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_issue(output bit e1, output bit e2);
    bit h1, h2, older1, coll;
    h1 = q1.size() > 0;
    h2 = q2.size() > 0;
    older1 = 1'b1;
    coll = 1'b0;
    if (h1 && h2) begin
      older1 = q1[0].age <= q2[0].age;
      coll   = q1[0].r == q2[0].r;
    end
    e1 = h1 && !(coll && !older1);
    e2 = h2 && !(coll && older1);
  endfunction

  function automatic logic [7:0] model_pend();
    logic [7:0] p = '0;
    foreach (q1[i]) p[q1[i].r] = 1'b1;
    foreach (q2[i]) p[q2[i].r] = 1'b1;
    return p;
  endfunction

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input logic v1, input logic [2:0] r1, input logic [15:0] d1,
                      input logic v2, input logic [2:0] r2, input logic [15:0] d2,
                      input logic w1, input logic w2);
    bit e1, e2, ok1, ok2;
    logic dcw1, dcw2;
    logic [2:0] dcs1, dcs2;
    logic [15:0] dcd1, dcd2;
    ent_t n;
    in1_vld = v1; in1_reg = r1; in1_dat = d1;
    in2_vld = v2; in2_reg = r2; in2_dat = d2;
    WT1 = w1; WT2 = w2;
    #1;
    model_issue(e1, e2);
    check("cw1", cw1, e1);
    check("cw2", cw2, e2);
    if (e1) begin check("cs1", cs1, q1[0].r); check("cd1", cd1, q1[0].d); end
    if (e2) begin check("cs2", cs2, q2[0].r); check("cd2", cd2, q2[0].d); end
    ok1 = q1.size() < DEPTH;
    ok2 = q2.size() < DEPTH;
    check("in1_rdy", in1_rdy, ok1);
    check("in2_rdy", in2_rdy, ok2);
    check("pend", pend, model_pend());
    dcw1 = cw1; dcs1 = cs1; dcd1 = cd1;
    dcw2 = cw2; dcs2 = cs2; dcd2 = cd2;
    @(posedge clk);
    if (dcw1 && !w1) rf_dut[dcs1] = dcd1;
    if (dcw2 && !w2) rf_dut[dcs2] = dcd2;
    if (e1 && !w1) begin rf_model[q1[0].r] = q1[0].d; void'(q1.pop_front()); end
    if (e2 && !w2) begin rf_model[q2[0].r] = q2[0].d; void'(q2.pop_front()); end
    if (v1 && ok1) begin n.r = r1; n.d = d1; n.age = edge_no; q1.push_back(n); end
    if (v2 && ok2) begin n.r = r2; n.d = d2; n.age = edge_no; q2.push_back(n); end
    if ((v1 && ok1) || (v2 && ok2)) edge_no++;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles, input logic w1, input logic w2);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, w1, w2);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin rf_model[i] = '0; rf_dut[i] = '0; end
    rst = 1'b0;
    in1_vld = 0; in1_reg = 0; in1_dat = 0;
    in2_vld = 0; in2_reg = 0; in2_dat = 0;
    WT1 = 0; WT2 = 0;
    #3;
    check("rst_cw1", cw1, 0);
    check("rst_cw2", cw2, 0);
    check("rst_pend", pend, 0);
    check("rst_rdy", {in1_rdy, in2_rdy}, 2'b11);
    check("rst_cs_cd", {cs1, cd1, cs2, cd2}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Single write appears the cycle after its push.
    step(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    check("t1_cw1", cw1, 1);
    check("t1_cs1", cs1, 3);
    check("t1_cd1", cd1, 16'h1234);
    check("t1_pend", pend, 8'h08);
    idle(1, 0, 0);
    check("t1_pend_clr", pend, 0);

    // Same-edge collision: channel 1 wins the tie, channel 2 lands last.
    step(1, 5, 16'hAAAA, 1, 5, 16'hBBBB, 0, 0);
    check("t2_cw", {cw1, cw2}, 2'b10);
    idle(1, 0, 0);
    check("t2_cw2", cw2, 1);
    check("t2_cd2", cd2, 16'hBBBB);
    idle(2, 0, 0);
    check("t2_r5", rf_dut[5], 16'hBBBB);

    // Older channel-2 entry held by WT2 blocks the younger channel-1 write.
    step(0, 0, 0, 1, 2, 16'h0002, 0, 1);
    step(1, 2, 16'h0001, 0, 0, 0, 0, 1);
    check("t3_cw1_blk", cw1, 0);
    idle(2, 0, 1);
    check("t3_cw1_blk2", cw1, 0);
    idle(3, 0, 0);
    check("t3_r2", rf_dut[2], 16'h0001);

    // Fill channel 1 while port 1 waits; the fifth request is dropped.
    for (int i = 0; i < 4; i++) step(1, 3'(i + 1), 16'(16'h0100 + i), 0, 0, 0, 1, 0);
    check("t4_full", in1_rdy, 0);
    step(1, 7, 16'hDEAD, 0, 0, 0, 1, 0);
    check("t4_qlen", q1.size(), 4);
    idle(5, 0, 0);
    check("t4_r4", rf_dut[4], 16'h0103);
    check("t4_r7", rf_dut[7], 16'h0000);

    // Random traffic over few registers forces collisions and stamp wrap.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 3'($urandom_range(0, 3)), 16'($urandom),
           $urandom_range(0, 1), 3'($urandom_range(0, 3)), 16'($urandom),
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
    idle(10, 0, 0);

    // Reset in the middle of a cycle discards queued entries at once.
    for (int i = 0; i < 3; i++) step(1, 3'(i + 4), 16'hF00 + 16'(i), 0, 0, 0, 1, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_cw", {cw1, cw2}, 2'b00);
    check("t6_pend", pend, 0);
    check("t6_rdy", {in1_rdy, in2_rdy}, 2'b11);
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst = 1'b1;
    idle(4, 0, 0);

    for (int i = 0; i < 8; i++) check($sformatf("rf%0d", i), rf_dut[i], rf_model[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
